// File: rtl/spi_receiver.sv
// rtl/spi_receiver.sv - SPI receive endpoint with idle-timeout frame alignment
//
// Oversamples a select-less, MSB-first SPI link (spi_clock idles high, data
// sampled on the rising edge) and presents each assembled byte on a one-entry
// valid/ready output buffer.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   spi_clock    serial clock, asynchronous, idles high
//   spi_data     serial data, asynchronous, idles high
//   rx_data      last received byte
//   rx_valid     rx_data holds an unconsumed byte
//   rx_ready     consumer accepts rx_data when rx_valid and rx_ready are high
//   rx_busy      frame reception in progress
//   rx_overrun   one-cycle pulse: a completed byte was dropped
//   frame_error  one-cycle pulse: a partial frame was discarded on timeout
module spi_receiver #(
    parameter int DATA_WIDTH   = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  spi_clock,
    input  logic                  spi_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_busy,
    output logic                  rx_overrun,
    output logic                  frame_error
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int TO_W  = $clog2(IDLE_TIMEOUT);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sclk_s;
    logic                   data_s;
    logic                   sclk_q;
    logic                   rise;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [TO_W-1:0]       timeout;
    logic [DATA_WIDTH-1:0] frame_byte;
    logic                  complete;

    // Both lines use the same depth so the sampled data stays aligned with
    // the sampled clock edge. Reset to the idle-high level so leaving reset
    // never fabricates a rising edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= '1;
            data_sync <= '1;
            sclk_q    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clock};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            sclk_q    <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_q;

    // Byte as it looks once the current bit is shifted in.
    assign frame_byte = {shift_reg[DATA_WIDTH-2:0], data_s};
    assign complete   = (state == SHIFT) && rise && (bit_cnt == LAST_BIT);
    assign rx_busy    = (state == SHIFT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            timeout     <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        shift_reg <= {{(DATA_WIDTH-1){1'b0}}, data_s};
                        bit_cnt   <= CNT_W'(1);
                        timeout   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A rise takes priority over an expiring timeout.
                    if (rise) begin
                        shift_reg <= frame_byte;
                        timeout   <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (timeout == TO_LAST) begin
                        // No select line: a stalled partial frame is dropped
                        // so the next rise starts a freshly aligned byte.
                        frame_error <= 1'b1;
                        shift_reg   <= '0;
                        bit_cnt     <= '0;
                        timeout     <= '0;
                        state       <= IDLE;
                    end else begin
                        timeout <= timeout + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry output buffer. A completion that coincides with an accept
    // reloads the buffer, so back-to-back frames never lose a byte when the
    // consumer keeps up.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= frame_byte;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_receiver.sv
// tb/tb_spi_receiver.sv - directed self-checking bench for spi_receiver
`timescale 1ns/1ps
module tb_spi_receiver;

    logic       clock;
    logic       reset;
    logic       spi_clock;
    logic       spi_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       rx_overrun;
    logic       frame_error;

    int errors = 0;
    int checks = 0;

    logic [7:0] accepted[$];
    int  ovr_cnt;
    int  fe_cnt;
    int  valid_cycles;
    int  valid_low;
    time last_rise_t;
    time valid_rise_t;
    time fe_t;
    logic vprev = 1'b0;

    spi_receiver #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2),
        .IDLE_TIMEOUT(32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .spi_clock  (spi_clock),
        .spi_data   (spi_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .rx_overrun (rx_overrun),
        .frame_error(frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observation on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (rx_valid && rx_ready) accepted.push_back(rx_data);
        if (rx_overrun) ovr_cnt++;
        if (frame_error) begin
            fe_cnt++;
            fe_t = $time;
        end
        if (rx_valid) valid_cycles++;
        else valid_low++;
        if (rx_valid && !vprev) valid_rise_t = $time;
        vprev = rx_valid;
    end

    task automatic clear_mon();
        accepted.delete();
        ovr_cnt      = 0;
        fe_cnt       = 0;
        valid_cycles = 0;
        valid_low    = 0;
    endtask

    task automatic wait_clocks(input int n);
        repeat (n) @(posedge clock);
        #3;
    endtask

    // 10 MHz transmitter: data changes with the falling spi_clock edge, MSB first.
    task automatic send_bits(input logic [7:0] val, input int nbits, input bit pulse_ready);
        for (int i = 0; i < nbits; i++) begin
            spi_clock = 1'b0;
            spi_data  = val[7-i];
            #50;
            spi_clock   = 1'b1;
            last_rise_t = $time;
            if (pulse_ready && i == nbits - 1) begin
                #20 rx_ready = 1'b1;
                #10 rx_ready = 1'b0;
                #20;
            end else begin
                #50;
            end
        end
        spi_data = 1'b1;
    endtask

    task automatic accept_one();
        @(negedge clock) rx_ready = 1'b1;
        @(negedge clock) rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_clears_valid: got %b want 0", rx_valid);
        end
        @(posedge clock);
        #3;
    endtask

    task automatic test_reset();
        reset = 1'b1; spi_clock = 1'b1; spi_data = 1'b1; rx_ready = 1'b0;
        clear_mon();
        wait_clocks(4);
        reset = 1'b0;
        wait_clocks(2);
        checks += 5;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
        if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_rx_overrun: got %b want 0", rx_overrun); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    endtask

    task automatic test_single();
        clear_mon();
        send_bits(8'hA5, 8, 1'b0);
        checks += 6;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rx_valid); end
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rx_data); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", rx_busy); end
        if (valid_rise_t - last_rise_t > 45 || valid_rise_t < last_rise_t) begin
            errors++;
            $display("FAIL single_latency: got %0t ns want <= 45 ns", valid_rise_t - last_rise_t);
        end
        if (ovr_cnt != 0) begin errors++; $display("FAIL single_overrun: got %0d want 0", ovr_cnt); end
        if (fe_cnt != 0) begin errors++; $display("FAIL single_frame_error: got %0d want 0", fe_cnt); end
        accept_one();
    endtask

    task automatic test_back_to_back();
        rx_ready = 1'b1;
        clear_mon();
        send_bits(8'h00, 8, 1'b0);
        send_bits(8'hFF, 8, 1'b0);
        send_bits(8'h3C, 8, 1'b0);
        wait_clocks(10);
        checks += 3;
        if (accepted.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", accepted.size());
        end else begin
            checks += 3;
            if (accepted[0] !== 8'h00) begin errors++; $display("FAIL b2b_byte0: got %h want 00", accepted[0]); end
            if (accepted[1] !== 8'hFF) begin errors++; $display("FAIL b2b_byte1: got %h want ff", accepted[1]); end
            if (accepted[2] !== 8'h3C) begin errors++; $display("FAIL b2b_byte2: got %h want 3c", accepted[2]); end
        end
        if (valid_cycles != 3) begin errors++; $display("FAIL b2b_valid_cycles: got %0d want 3", valid_cycles); end
        if (ovr_cnt != 0) begin errors++; $display("FAIL b2b_overrun: got %0d want 0", ovr_cnt); end
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        clear_mon();
        send_bits(8'h12, 8, 1'b0);
        send_bits(8'h34, 8, 1'b0);
        wait_clocks(5);
        checks += 3;
        if (rx_data !== 8'h12) begin errors++; $display("FAIL ovr_data_kept: got %h want 12", rx_data); end
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_kept: got %b want 1", rx_valid); end
        if (ovr_cnt != 1) begin errors++; $display("FAIL ovr_pulse_count: got %0d want 1", ovr_cnt); end
        accept_one();
    endtask

    task automatic test_timeout();
        rx_ready = 1'b0;
        clear_mon();
        send_bits(8'hF0, 5, 1'b0);
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL to_busy_partial: got %b want 1", rx_busy); end
        #400;
        checks += 4;
        if (fe_cnt != 1) begin errors++; $display("FAIL to_frame_error_count: got %0d want 1", fe_cnt); end
        else if (fe_t - last_rise_t < 320 || fe_t - last_rise_t > 360) begin
            errors++;
            $display("FAIL to_frame_error_time: got %0t ns want 320..360 ns", fe_t - last_rise_t);
        end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL to_valid_low: got %b want 0", rx_valid); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL to_busy_cleared: got %b want 0", rx_busy); end
        send_bits(8'h81, 8, 1'b0);
        checks += 2;
        if (rx_data !== 8'h81) begin errors++; $display("FAIL to_realign_data: got %h want 81", rx_data); end
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL to_realign_valid: got %b want 1", rx_valid); end
        accept_one();
    endtask

    task automatic test_reset_mid_frame();
        rx_ready = 1'b0;
        clear_mon();
        send_bits(8'h55, 4, 1'b0);
        reset = 1'b1;
        wait_clocks(3);
        reset = 1'b0;
        wait_clocks(2);
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", rx_busy); end
        send_bits(8'hC3, 8, 1'b0);
        wait_clocks(40);
        checks += 3;
        if (fe_cnt != 0) begin errors++; $display("FAIL rst_mid_frame_error: got %0d want 0", fe_cnt); end
        if (rx_data !== 8'hC3) begin errors++; $display("FAIL rst_mid_data: got %h want c3", rx_data); end
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_valid: got %b want 1", rx_valid); end
        accept_one();
    endtask

    task automatic test_back_to_back_accept();
        rx_ready = 1'b0;
        send_bits(8'h11, 8, 1'b0);
        clear_mon();
        // rx_ready is high only in the cycle whose edge registers completion.
        send_bits(8'h22, 8, 1'b1);
        wait_clocks(3);
        checks += 5;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL sim_valid: got %b want 1", rx_valid); end
        if (rx_data !== 8'h22) begin errors++; $display("FAIL sim_data: got %h want 22", rx_data); end
        if (ovr_cnt != 0) begin errors++; $display("FAIL sim_overrun: got %0d want 0", ovr_cnt); end
        if (valid_low != 0) begin errors++; $display("FAIL sim_valid_gap: got %0d low cycles want 0", valid_low); end
        if (accepted.size() != 1 || accepted[0] !== 8'h11) begin
            errors++;
            $display("FAIL sim_accepted_old: got %0d entries want one entry of 11", accepted.size());
        end
        accept_one();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back_accept();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
